// File: rtl/alu_issue_buffer_pkg.sv
// Shared definitions for the ALU issue buffer: opcode encodings, entry layout, depth.
// Opcodes 5-7 are not ALU operations and are flagged illegal at dispatch.
package alu_issue_buffer_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 3;
   localparam int DEPTH  = 2;

   localparam logic [OP_W-1:0] OP_ADD        = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB        = 3'd1;
   localparam logic [OP_W-1:0] OP_AND        = 3'd2;
   localparam logic [OP_W-1:0] OP_OR         = 3'd3;
   localparam logic [OP_W-1:0] OP_NOR        = 3'd4;
   localparam logic [OP_W-1:0] OP_LAST_LEGAL = 3'd4;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
      logic              fwd_a;
      logic              fwd_b;
   } entry_t;

   // Only ADD/SUB can legitimately raise overflow.
   function automatic logic op_is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_issue_buffer_fifo2.sv
// Two-entry circular storage with 1-bit pointers and an occupancy count.
// Push/pop arrive already qualified by the owner's handshake.
module issue_fifo2 #(
   parameter int W = 72
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_mem [0:1];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_count;

   // Entry storage needs no reset; the count decides what is live.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (i_push) r_wptr <= ~r_wptr;
         if (i_pop)  r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/alu_issue_buffer.sv
// Issue buffer in front of the combinational ALU: 2-entry elastic FIFO, result
// forwarding from the last dispatch, sticky overflow and illegal-opcode marking.
module alu_issue_buffer
   import alu_issue_buffer_pkg::*;
#(
   parameter int N     = 32,
   parameter int OPW   = 3,
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   input  logic [OPW-1:0] in_op,
   input  logic           in_fwd_a,
   input  logic           in_fwd_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   output logic [OPW-1:0] alu_op,
   output logic           op_illegal,
   input  logic [N-1:0]   alu_c,
   input  logic           alu_ov,
   output logic [N-1:0]   last_res,
   output logic           ov_sticky,
   input  logic           clr_ov
);

   localparam int EW = 2*N + OPW + 2;

   logic [EW-1:0]  w_in_entry;
   logic [EW-1:0]  w_head;
   logic [1:0]     w_count;
   logic           w_push;
   logic           w_pop;
   logic [N-1:0]   w_head_a;
   logic [N-1:0]   w_head_b;
   logic [OPW-1:0] w_head_op;
   logic           w_head_fa;
   logic           w_head_fb;
   logic           w_ov_set;
   logic [N-1:0]   r_last_res;
   logic           r_ov_sticky;

   assign in_ready  = (w_count != 2'(DEPTH));
   assign out_valid = (w_count != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   // Operands are stored raw; forwarding is resolved only when the entry is at the head.
   assign w_in_entry = {in_a, in_b, in_op, in_fwd_a, in_fwd_b};

   issue_fifo2 #(.W(EW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_in_entry),
      .o_data  (w_head),
      .o_count (w_count)
   );

   assign {w_head_a, w_head_b, w_head_op, w_head_fa, w_head_fb} = w_head;

   always_comb begin
      alu_a      = '0;
      alu_b      = '0;
      alu_op     = '0;
      op_illegal = 1'b0;
      if (out_valid) begin
         alu_a      = w_head_fa ? r_last_res : w_head_a;
         alu_b      = w_head_fb ? r_last_res : w_head_b;
         alu_op     = w_head_op;
         op_illegal = (w_head_op > OPW'(OP_LAST_LEGAL));
      end
   end

   assign w_ov_set = w_pop & alu_ov & op_is_arith(OP_W'(w_head_op));

   // Illegal ops still dispatch; the ALU returns 0 for them, which becomes last_res.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_res  <= '0;
         r_ov_sticky <= 1'b0;
      end else begin
         if (w_pop) r_last_res <= alu_c;
         if (w_ov_set)    r_ov_sticky <= 1'b1;
         else if (clr_ov) r_ov_sticky <= 1'b0;
      end
   end

   assign last_res  = r_last_res;
   assign ov_sticky = r_ov_sticky;

endmodule
